// File: rtl/ext_io_port.sv
// Environment side of the SCPU external I/O port: a host-to-CPU input FIFO
// and a CPU-to-host output FIFO, each with first-word fall-through heads.
module ext_io_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    host_in_data,
  input  logic          host_in_valid,
  output logic          host_in_ready,
  input  logic          cpu_in_rd,
  output logic [7:0]    ext_in,
  output logic          in_empty,
  output logic [AW:0]   in_count,
  input  logic          cpu_out_we,
  input  logic [7:0]    ext_out,
  output logic          out_full,
  output logic [AW:0]   out_count,
  output logic [7:0]    host_out_data,
  output logic          host_out_valid,
  input  logic          host_out_ready,
  input  logic          clr_err,
  output logic          underflow,
  output logic          overflow
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  in_mem_r  [DEPTH];
  logic [7:0]  out_mem_r [DEPTH];
  logic [AW:0] in_wp_r, in_rp_r, out_wp_r, out_rp_r;
  logic        underflow_r, overflow_r;

  logic in_empty_s, in_full_s, in_push_s, in_pop_s, in_under_s;
  logic out_empty_s, out_full_s, out_push_s, out_pop_s, out_drop_s;

  // Occupancy decode: extra pointer bit distinguishes full from empty.
  assign in_empty_s  = (in_wp_r == in_rp_r);
  assign in_full_s   = (in_wp_r[AW] != in_rp_r[AW]) &&
                       (in_wp_r[AW-1:0] == in_rp_r[AW-1:0]);
  assign out_empty_s = (out_wp_r == out_rp_r);
  assign out_full_s  = (out_wp_r[AW] != out_rp_r[AW]) &&
                       (out_wp_r[AW-1:0] == out_rp_r[AW-1:0]);

  assign in_push_s  = host_in_valid && !in_full_s;
  assign in_pop_s   = cpu_in_rd && !in_empty_s;
  assign in_under_s = cpu_in_rd && in_empty_s;

  // A full output FIFO still takes a write when the host drains the head in the same cycle.
  assign out_pop_s  = host_out_ready && !out_empty_s;
  assign out_push_s = cpu_out_we && (!out_full_s || out_pop_s);
  assign out_drop_s = cpu_out_we && out_full_s && !out_pop_s;

  assign host_in_ready  = !in_full_s;
  assign in_empty       = in_empty_s;
  assign in_count       = in_wp_r - in_rp_r;
  assign out_full       = out_full_s;
  assign out_count      = out_wp_r - out_rp_r;
  assign host_out_valid = !out_empty_s;
  assign underflow      = underflow_r;
  assign overflow       = overflow_r;

  // Fall-through heads, forced to zero when the FIFO is empty.
  always_comb begin
    ext_in        = 8'h00;
    host_out_data = 8'h00;
    if (!in_empty_s) begin
      ext_in = in_mem_r[in_rp_r[AW-1:0]];
    end else begin
      ext_in = 8'h00;
    end
    if (!out_empty_s) begin
      host_out_data = out_mem_r[out_rp_r[AW-1:0]];
    end else begin
      host_out_data = 8'h00;
    end
  end

  // Storage writes; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst && in_push_s) begin
      in_mem_r[in_wp_r[AW-1:0]] <= host_in_data;
    end
    if (rst && out_push_s) begin
      out_mem_r[out_wp_r[AW-1:0]] <= ext_out;
    end
  end

  // Pointer updates for both FIFOs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_wp_r  <= '0;
      in_rp_r  <= '0;
      out_wp_r <= '0;
      out_rp_r <= '0;
    end else begin
      if (in_push_s)  in_wp_r  <= in_wp_r + PTR_ONE;
      if (in_pop_s)   in_rp_r  <= in_rp_r + PTR_ONE;
      if (out_push_s) out_wp_r <= out_wp_r + PTR_ONE;
      if (out_pop_s)  out_rp_r <= out_rp_r + PTR_ONE;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      underflow_r <= (underflow_r && !clr_err) || in_under_s;
      overflow_r  <= (overflow_r && !clr_err) || out_drop_s;
    end
  end

endmodule

// File: tb/tb_ext_io_port.sv
// Bench for ext_io_port: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ext_io_port;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic          cpu_in_rd;
  logic [7:0]    ext_in;
  logic          in_empty;
  logic [AW:0]   in_count;
  logic          cpu_out_we;
  logic [7:0]    ext_out;
  logic          out_full;
  logic [AW:0]   out_count;
  logic [7:0]    host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic          clr_err;
  logic          underflow;
  logic          overflow;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic [7:0] m_in[$];
  logic [7:0] m_out[$];
  bit         m_uf, m_of;

  ext_io_port #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .cpu_in_rd(cpu_in_rd), .ext_in(ext_in),
    .in_empty(in_empty), .in_count(in_count), .cpu_out_we(cpu_out_we),
    .ext_out(ext_out), .out_full(out_full), .out_count(out_count),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready), .clr_err(clr_err),
    .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues and two sticky flags.
  always @(posedge clk) begin
    bit in_pop, in_push, uf_evt, out_pop, out_acc, of_evt;
    if (!rst) begin
      m_in.delete();
      m_out.delete();
      m_uf = 1'b0;
      m_of = 1'b0;
    end else begin
      in_pop  = cpu_in_rd && (m_in.size() > 0);
      uf_evt  = cpu_in_rd && (m_in.size() == 0);
      in_push = host_in_valid && (m_in.size() < DEPTH);
      out_pop = host_out_ready && (m_out.size() > 0);
      out_acc = cpu_out_we && ((m_out.size() < DEPTH) || out_pop);
      of_evt  = cpu_out_we && !out_acc;
      if (in_pop)  void'(m_in.pop_front());
      if (in_push) m_in.push_back(host_in_data);
      if (out_pop) void'(m_out.pop_front());
      if (out_acc) m_out.push_back(ext_out);
      m_uf = (m_uf && !clr_err) || uf_evt;
      m_of = (m_of && !clr_err) || of_evt;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ext_in",     ext_in,        (m_in.size() > 0) ? m_in[0] : 8'h00);
      check("m_in_count",   8'(in_count),  8'(m_in.size()));
      check("m_in_empty",   8'(in_empty),  8'(m_in.size() == 0));
      check("m_in_ready",   8'(host_in_ready), 8'(m_in.size() < DEPTH));
      check("m_host_data",  host_out_data, (m_out.size() > 0) ? m_out[0] : 8'h00);
      check("m_out_count",  8'(out_count), 8'(m_out.size()));
      check("m_out_full",   8'(out_full),  8'(m_out.size() == DEPTH));
      check("m_out_valid",  8'(host_out_valid), 8'(m_out.size() > 0));
      check("m_underflow",  8'(underflow), 8'(m_uf));
      check("m_overflow",   8'(overflow),  8'(m_of));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_seq [6];
    rst = 1'b0; host_in_data = 8'h00; host_in_valid = 1'b0; cpu_in_rd = 1'b0;
    cpu_out_we = 1'b0; ext_out = 8'h00; host_out_ready = 1'b0; clr_err = 1'b0;
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    check("rst_in_ready", 8'(host_in_ready), 8'h01);
    check("rst_in_empty", 8'(in_empty), 8'h01);
    check("rst_in_count", 8'(in_count), 8'h00);
    check("rst_ext_in", ext_in, 8'h00);
    check("rst_out_full", 8'(out_full), 8'h00);
    check("rst_out_count", 8'(out_count), 8'h00);
    check("rst_out_valid", 8'(host_out_valid), 8'h00);
    check("rst_host_data", host_out_data, 8'h00);

    // 1: two pushes, one pop
    host_in_valid = 1'b1; host_in_data = 8'hA5; tick();
    host_in_data = 8'h3C; tick();
    host_in_valid = 1'b0;
    check("t1_count2", 8'(in_count), 8'h02);
    check("t1_head_a5", ext_in, 8'hA5);
    cpu_in_rd = 1'b1; tick(); cpu_in_rd = 1'b0;
    check("t1_head_3c", ext_in, 8'h3C);
    check("t1_count1", 8'(in_count), 8'h01);
    cpu_in_rd = 1'b1; tick(); cpu_in_rd = 1'b0;

    // 2: fill, hold off, over-drain, refill across wrap
    for (int i = 1; i <= 4; i++) begin
      host_in_valid = 1'b1; host_in_data = 8'(i); tick();
    end
    check("t2_ready0", 8'(host_in_ready), 8'h00);
    check("t2_count4", 8'(in_count), 8'h04);
    host_in_data = 8'hAA; tick(); host_in_valid = 1'b0;
    check("t2_held_count", 8'(in_count), 8'h04);
    check("t2_held_head", ext_in, 8'h01);
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h03;
    exp_seq[3] = 8'h04; exp_seq[4] = 8'h00; exp_seq[5] = 8'h00;
    cpu_in_rd = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_pop%0d", k), ext_in, exp_seq[k]);
      tick();
      if (k == 0) check("t2_ready_back", 8'(host_in_ready), 8'h01);
      if (k == 3) check("t2_uf_before", 8'(underflow), 8'h00);
      if (k == 4) check("t2_uf_after", 8'(underflow), 8'h01);
    end
    cpu_in_rd = 1'b0;
    host_in_valid = 1'b1; host_in_data = 8'h05; tick(); host_in_valid = 1'b0;
    check("t2_refill", ext_in, 8'h05);
    check("t2_refill_cnt", 8'(in_count), 8'h01);
    cpu_in_rd = 1'b1; clr_err = 1'b1; tick(); cpu_in_rd = 1'b0; clr_err = 1'b0;
    check("t2_uf_clr", 8'(underflow), 8'h00);

    // 3: five writes into a four-deep FIFO, then drain
    cpu_out_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ext_out = 8'h10 + 8'(i); tick();
    end
    cpu_out_we = 1'b0;
    check("t3_count4", 8'(out_count), 8'h04);
    check("t3_overflow", 8'(overflow), 8'h01);
    host_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_drain%0d", k), host_out_data, 8'h10 + 8'(k));
      tick();
    end
    host_out_ready = 1'b0;
    check("t3_valid0", 8'(host_out_valid), 8'h00);

    // 4: write into a full FIFO while the host pops
    cpu_out_we = 1'b1; clr_err = 1'b1; ext_out = 8'h20; tick(); clr_err = 1'b0;
    for (int i = 1; i < 4; i++) begin
      ext_out = 8'h20 + 8'(i); tick();
    end
    check("t4_full", 8'(out_full), 8'h01);
    ext_out = 8'h77; host_out_ready = 1'b1; tick(); cpu_out_we = 1'b0;
    check("t4_of0", 8'(overflow), 8'h00);
    check("t4_count4", 8'(out_count), 8'h04);
    exp_seq[0] = 8'h21; exp_seq[1] = 8'h22; exp_seq[2] = 8'h23; exp_seq[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_drain%0d", k), host_out_data, exp_seq[k]);
      tick();
    end
    host_out_ready = 1'b0;

    // 5: reset discards queued bytes; no edge means no change
    cpu_in_rd = 1'b1; tick(); cpu_in_rd = 1'b0;
    host_in_valid = 1'b1; cpu_out_we = 1'b1;
    host_in_data = 8'hB1; ext_out = 8'hC1; tick();
    host_in_data = 8'hB2; ext_out = 8'hC2; tick();
    host_in_valid = 1'b0; cpu_out_we = 1'b0;
    check("t5_in2", 8'(in_count), 8'h02);
    check("t5_out2", 8'(out_count), 8'h02);
    rst = 1'b0; host_in_valid = 1'b1; host_in_data = 8'hDD;
    #2;
    check("t5_hold_in", 8'(in_count), 8'h02);
    check("t5_hold_head", ext_in, 8'hB1);
    check("t5_hold_uf", 8'(underflow), 8'h01);
    tick();
    rst = 1'b1; host_in_valid = 1'b0;
    check("t5_in0", 8'(in_count), 8'h00);
    check("t5_ext0", ext_in, 8'h00);
    check("t5_valid0", 8'(host_out_valid), 8'h00);
    check("t5_uf0", 8'(underflow), 8'h00);

    // 6: set wins over clear
    cpu_in_rd = 1'b1; tick();
    clr_err = 1'b1; tick();
    check("t6_set_wins", 8'(underflow), 8'h01);
    cpu_in_rd = 1'b0; tick(); clr_err = 1'b0;
    check("t6_cleared", 8'(underflow), 8'h00);

    // All four handshakes together, then a mixed-traffic run against the model
    host_in_valid = 1'b1; host_in_data = 8'h61; cpu_out_we = 1'b1; ext_out = 8'h71; tick();
    host_in_data = 8'h62; ext_out = 8'h72; cpu_in_rd = 1'b1; host_out_ready = 1'b1; tick();
    check("all4_in_cnt", 8'(in_count), 8'h01);
    check("all4_head", ext_in, 8'h62);
    check("all4_out_head", host_out_data, 8'h72);
    for (int c = 0; c < 120; c++) begin
      host_in_valid  = 1'($urandom_range(0, 1));
      host_in_data   = 8'($urandom);
      cpu_in_rd      = 1'($urandom_range(0, 2) == 0);
      cpu_out_we     = 1'($urandom_range(0, 1));
      ext_out        = 8'($urandom);
      host_out_ready = 1'($urandom_range(0, 2) == 0);
      clr_err        = 1'($urandom_range(0, 9) == 0);
      tick();
    end
    host_in_valid = 1'b0; cpu_in_rd = 1'b0; cpu_out_we = 1'b0;
    host_out_ready = 1'b0; clr_err = 1'b0;
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
